mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- MEM/WB pipeline register plus write-back selection for the MIPS core; sits directly downstream of the memory stage and drives the register-file write port.
- Latches memory read data, ALU result, return address and control from MEM, then selects write-back data.
- Detects program end (HALT reaching write-back), freezes the stage, and counts retired instructions for the debug unit.

Parameters:
IO_BUS_SIZE, 32, data bus width
REG_ADDR_SIZE, 5, register-file address width
COUNTER_SIZE, 32, retired-instruction counter width

Ports:
i_clk  input  1  clock, all state on rising edge
i_reset  input  1  synchronous, active-high reset
i_enable  input  1  stage advance (low = stall/debug hold)
i_flush  input  1  synchronous clear of stage, FSM and counter (program reload)
i_valid  input  1  MEM-stage entry is a real instruction (0 = bubble)
i_halt  input  1  MEM-stage entry is the HALT instruction
i_reg_wr  input  1  entry writes the register file
i_wb_src  input  2  0 = ALU result, 1 = memory read data, 2 = return address, 3 = zero
i_rd_addr  input  REG_ADDR_SIZE  destination register
i_mem_rd  input  IO_BUS_SIZE  extended read data from the memory stage
i_alu_result  input  IO_BUS_SIZE  ALU result forwarded through MEM
i_return_addr  input  IO_BUS_SIZE  link address for JAL/JALR
o_wb_data  output  IO_BUS_SIZE  write-back data
o_wb_reg_addr  output  REG_ADDR_SIZE  write-back destination
o_wb_reg_wr  output  1  register-file write strobe
o_halt  output  1  program finished, stage frozen
o_retired  output  COUNTER_SIZE  retired-instruction count

Behaviour:
- Reset: synchronous, active-high; one clock; i_clk, i_reset.
- On reset: all latched fields 0, FSM = RUN, counter 0. Outputs: o_wb_data 0, o_wb_reg_addr 0, o_wb_reg_wr 0, o_halt 0, o_retired 0.
- Priority per edge: i_reset > i_flush > HALTED freeze > i_enable latch > hold.
- i_flush acts like reset: latch cleared to a bubble, FSM → RUN, counter → 0. It applies in either state.
- Latch at edge N when state = RUN and i_enable = 1: all inputs are captured. The entry appears on outputs during cycle N+1, so latency is 1 cycle.
- i_enable = 0: latch holds and outputs are stable. A held entry's o_wb_reg_wr stays asserted; the register-file rewrite is idempotent.
- o_wb_data is combinational from latched fields via the wb_src mux; src 3 gives all zeros.
- o_wb_reg_addr = latched rd.
- o_wb_reg_wr = valid & reg_wr & ~halt & (rd != 0) & (state == RUN). Writes to $0 are suppressed.
- FSM RUN → HALTED at the edge after a latched entry has valid = 1 and halt = 1. o_halt is registered (= state == HALTED), so it rises 1 cycle after the HALT entry appears at the outputs.
- FSM HALTED: latch is frozen and inputs are ignored (i_enable is don't-care). o_wb_reg_wr = 0, o_halt = 1. Exit only via i_reset or i_flush.
- Counter: increments by 1 at each edge where the stage latches (RUN & i_enable & ~i_flush) an entry with i_valid = 1 and i_halt = 0. Bubbles and HALT are not counted.
- Counter saturates at 2^COUNTER_SIZE − 1 and does not wrap.
- Simultaneous HALT latched in the latch while a new entry arrives in the same cycle: the new entry is still latched and counted at that edge (state is still RUN). From the next edge the stage is frozen.
- A bubble with i_halt = 1 and i_valid = 0 does not halt.
- Reset or flush mid-stall or mid-halt clears everything in that cycle.

Test Plan:
- Reset then one enabled cycle with valid = 1, reg_wr = 1, rd = 8, wb_src = 0, alu = 0x0000_1234 → next cycle o_wb_data = 0x1234, addr 8, wr = 1, o_retired = 1.
- Back-to-back entries with wb_src 1/2/3: mem_rd = 0xFFFF_FF80, ret = 0x0000_0048 → outputs 0xFFFF_FF80, 0x48, 0x0 on consecutive cycles; o_retired increments 1, 2, 3.
- rd = 0 with reg_wr = 1 → o_wb_reg_wr = 0; bubble (valid = 0) → wr = 0 and counter unchanged.
- i_enable low for 3 cycles with changing inputs → outputs and counter unchanged; on release the next input appears 1 cycle later.
- HALT entry after 4 instructions → o_halt = 1 one cycle after the HALT entry appears. Further inputs (enable = 1) are ignored, wr = 0, o_retired holds 4 (or 5 if an entry was latched alongside the latched HALT).
- While halted, pulse i_flush → o_halt = 0, o_retired = 0, wr = 0; a new entry is accepted the following cycle.

Source files
------------

// File: rtl/mem_wb_stage.sv
// -----------------------------------------------------------------------------
// mem_wb_stage
//
// MEM/WB pipeline register and write-back selection for the MIPS core.
// Captures one MEM-stage entry per enabled cycle, selects the data that is
// written back to the register file, freezes once a HALT entry reaches
// write-back, and counts retired instructions for the debug unit.
//
// Ports
//   i_clk, i_reset    clock; synchronous active-high reset
//   i_enable          stage advance (low = stall / debug hold)
//   i_flush           synchronous clear of latch, FSM and counter
//   i_valid, i_halt   entry is a real instruction / entry is HALT
//   i_reg_wr          entry writes the register file
//   i_wb_src          0 = ALU, 1 = memory data, 2 = return address, 3 = zero
//   i_rd_addr         destination register
//   i_mem_rd          extended read data from the memory stage
//   i_alu_result      ALU result forwarded through MEM
//   i_return_addr     link address for JAL/JALR
//   o_wb_data         write-back data (combinational from the latch)
//   o_wb_reg_addr     write-back destination
//   o_wb_reg_wr       register-file write strobe
//   o_halt            program finished, stage frozen (FSM state)
//   o_retired         saturating retired-instruction count
//
// Handshake: there is no ready path. An entry is accepted on every rising
// edge where the stage is running and i_enable is high; i_valid only marks
// whether that accepted entry is a real instruction or a bubble.
// -----------------------------------------------------------------------------
module mem_wb_stage #(
    parameter int IO_BUS_SIZE   = 32,
    parameter int REG_ADDR_SIZE = 5,
    parameter int COUNTER_SIZE  = 32
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_enable,
    input  logic                     i_flush,
    input  logic                     i_valid,
    input  logic                     i_halt,
    input  logic                     i_reg_wr,
    input  logic [1:0]               i_wb_src,
    input  logic [REG_ADDR_SIZE-1:0] i_rd_addr,
    input  logic [IO_BUS_SIZE-1:0]   i_mem_rd,
    input  logic [IO_BUS_SIZE-1:0]   i_alu_result,
    input  logic [IO_BUS_SIZE-1:0]   i_return_addr,
    output logic [IO_BUS_SIZE-1:0]   o_wb_data,
    output logic [REG_ADDR_SIZE-1:0] o_wb_reg_addr,
    output logic                     o_wb_reg_wr,
    output logic                     o_halt,
    output logic [COUNTER_SIZE-1:0]  o_retired
);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    localparam logic [COUNTER_SIZE-1:0] CNT_MAX = '1;
    localparam logic [COUNTER_SIZE-1:0] CNT_ONE = COUNTER_SIZE'(1);

    state_t                   state;
    logic                     lat_valid;
    logic                     lat_halt;
    logic                     lat_reg_wr;
    logic [1:0]               lat_wb_src;
    logic [REG_ADDR_SIZE-1:0] lat_rd;
    logic [IO_BUS_SIZE-1:0]   lat_mem_rd;
    logic [IO_BUS_SIZE-1:0]   lat_alu;
    logic [IO_BUS_SIZE-1:0]   lat_ret;
    logic [COUNTER_SIZE-1:0]  retired;

    // Reset and flush are indistinguishable in effect: flush exists so a
    // program reload can clear the stage without a core-wide reset.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            state      <= ST_RUN;
            lat_valid  <= 1'b0;
            lat_halt   <= 1'b0;
            lat_reg_wr <= 1'b0;
            lat_wb_src <= 2'd0;
            lat_rd     <= '0;
            lat_mem_rd <= '0;
            lat_alu    <= '0;
            lat_ret    <= '0;
            retired    <= '0;
        end else if (state == ST_RUN) begin
            // The HALT entry currently at write-back freezes the stage from
            // the next edge; this edge still accepts (and counts) a new entry.
            if (lat_valid && lat_halt) begin
                state <= ST_HALTED;
            end
            if (i_enable) begin
                lat_valid  <= i_valid;
                lat_halt   <= i_halt;
                lat_reg_wr <= i_reg_wr;
                lat_wb_src <= i_wb_src;
                lat_rd     <= i_rd_addr;
                lat_mem_rd <= i_mem_rd;
                lat_alu    <= i_alu_result;
                lat_ret    <= i_return_addr;
                if (i_valid && !i_halt && (retired != CNT_MAX)) begin
                    retired <= retired + CNT_ONE;
                end
            end
        end
        // ST_HALTED: everything holds until reset or flush.
    end

    always_comb begin
        o_wb_data = '0;
        case (lat_wb_src)
            2'd0:    o_wb_data = lat_alu;
            2'd1:    o_wb_data = lat_mem_rd;
            2'd2:    o_wb_data = lat_ret;
            default: o_wb_data = '0;
        endcase
    end

    assign o_wb_reg_addr = lat_rd;
    // $0 is hard-wired zero, so writes to it are dropped here.
    assign o_wb_reg_wr   = lat_valid && lat_reg_wr && !lat_halt &&
                           (lat_rd != '0) && (state == ST_RUN);
    assign o_halt        = (state == ST_HALTED);
    assign o_retired     = retired;

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

  localparam int W  = 32;
  localparam int AW = 5;
  localparam int CW = 4;   // narrow counter so saturation is reachable
  localparam int CNT_MAX = (1 << CW) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, enable, flush, valid, halt, reg_wr;
  logic [1:0]    wb_src;
  logic [AW-1:0] rd_addr;
  logic [W-1:0]  mem_rd, alu_result, return_addr;
  logic [W-1:0]  wb_data;
  logic [AW-1:0] wb_reg_addr;
  logic          wb_reg_wr, halt_o;
  logic [CW-1:0] retired;

  mem_wb_stage #(.IO_BUS_SIZE(W), .REG_ADDR_SIZE(AW), .COUNTER_SIZE(CW)) dut (
    .i_clk(clk), .i_reset(reset), .i_enable(enable), .i_flush(flush),
    .i_valid(valid), .i_halt(halt), .i_reg_wr(reg_wr), .i_wb_src(wb_src),
    .i_rd_addr(rd_addr), .i_mem_rd(mem_rd), .i_alu_result(alu_result),
    .i_return_addr(return_addr), .o_wb_data(wb_data),
    .o_wb_reg_addr(wb_reg_addr), .o_wb_reg_wr(wb_reg_wr), .o_halt(halt_o),
    .o_retired(retired)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The stage holds "the entry at write-back"; a program that has seen HALT
  // reach write-back is finished; the count is of accepted real non-HALT
  // instructions, clamped at the maximum.
  typedef struct {
    bit       valid, halt, reg_wr;
    int       src;
    int       rd;
    bit [W-1:0] mem, alu, ret;
  } entry_t;

  entry_t m_ent;
  bit     m_finished;
  int     m_count;

  function automatic entry_t empty_entry();
    entry_t e;
    e.valid = 0; e.halt = 0; e.reg_wr = 0; e.src = 0; e.rd = 0;
    e.mem = '0; e.alu = '0; e.ret = '0;
    return e;
  endfunction

  always @(posedge clk) begin
    if (reset || flush) begin
      m_ent = empty_entry();
      m_finished = 0;
      m_count = 0;
    end else if (!m_finished) begin
      bit halt_seen;
      halt_seen = m_ent.valid && m_ent.halt;
      if (enable) begin
        m_ent.valid = valid; m_ent.halt = halt; m_ent.reg_wr = reg_wr;
        m_ent.src = int'(wb_src); m_ent.rd = int'(rd_addr);
        m_ent.mem = mem_rd; m_ent.alu = alu_result; m_ent.ret = return_addr;
        if (valid && !halt) m_count = (m_count < CNT_MAX) ? m_count + 1 : CNT_MAX;
      end
      if (halt_seen) m_finished = 1;
    end
  end

  function automatic logic [W-1:0] exp_data();
    if (m_ent.src == 0) return m_ent.alu;
    if (m_ent.src == 1) return m_ent.mem;
    if (m_ent.src == 2) return m_ent.ret;
    return '0;
  endfunction

  // ---------------- compare process (every cycle once armed) ----------------
  bit chk_on = 0;
  always @(negedge clk) begin
    if (chk_on) begin
      chk("wb_data", wb_data, exp_data());
      chk("wb_reg_addr", W'(wb_reg_addr), W'(m_ent.rd));
      chk("wb_reg_wr", W'(wb_reg_wr),
          W'(m_ent.valid && m_ent.reg_wr && !m_ent.halt && m_ent.rd != 0 && !m_finished));
      chk("halt", W'(halt_o), W'(m_finished));
      chk("retired", W'(retired), W'(m_count));
    end
  end

  // ---------------- driver ----------------
  task automatic step(input bit rs, input bit fl, input bit en, input bit v, input bit h,
                      input bit rw, input int src, input int rd,
                      input logic [W-1:0] mem, input logic [W-1:0] alu, input logic [W-1:0] ret);
    reset = rs; flush = fl; enable = en; valid = v; halt = h; reg_wr = rw;
    wb_src = 2'(src); rd_addr = AW'(rd); mem_rd = mem; alu_result = alu; return_addr = ret;
    @(posedge clk);
    #1;
  endtask

  task automatic step_rand(input int p_rs, input int p_fl, input int p_en, input int p_h);
    step($urandom_range(0, 99) < p_rs, $urandom_range(0, 99) < p_fl,
         $urandom_range(0, 99) < p_en, $urandom_range(0, 99) < 80,
         $urandom_range(0, 99) < p_h, $urandom_range(0, 1) == 1,
         $urandom_range(0, 3), $urandom_range(0, 31),
         $urandom(), $urandom(), $urandom());
  endtask

  // ---------------- stimulus with literal expectations ----------------
  initial begin
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk_on = 1;
    step(1, 0, 1, 1, 0, 1, 1, 7, 32'hDEAD, 32'hBEEF, 32'h4);
    chk("reset data", wb_data, 0);
    chk("reset addr", W'(wb_reg_addr), 0);
    chk("reset wr", W'(wb_reg_wr), 0);
    chk("reset halt", W'(halt_o), 0);
    chk("reset retired", W'(retired), 0);

    step(0, 0, 1, 1, 0, 1, 0, 8, 0, 32'h0000_1234, 0);
    chk("t1 data", wb_data, 32'h1234);
    chk("t1 addr", W'(wb_reg_addr), 8);
    chk("t1 wr", W'(wb_reg_wr), 1);
    chk("t1 retired", W'(retired), 1);

    step(0, 0, 1, 1, 0, 1, 1, 9, 32'hFFFF_FF80, 32'h1, 32'h48);
    chk("src1 data", wb_data, 32'hFFFF_FF80);
    chk("src1 retired", W'(retired), 2);
    step(0, 0, 1, 1, 0, 1, 2, 9, 32'hFFFF_FF80, 32'h1, 32'h48);
    chk("src2 data", wb_data, 32'h48);
    chk("src2 retired", W'(retired), 3);
    step(0, 0, 1, 1, 0, 1, 3, 9, 32'hFFFF_FF80, 32'h1, 32'h48);
    chk("src3 data", wb_data, 0);
    chk("src3 wr", W'(wb_reg_wr), 1);
    chk("src3 retired", W'(retired), 4);

    step(0, 0, 1, 1, 0, 1, 0, 0, 0, 32'h7, 0);
    chk("rd0 wr", W'(wb_reg_wr), 0);
    chk("rd0 retired", W'(retired), 5);
    step(0, 0, 1, 0, 0, 1, 0, 5, 0, 32'h99, 0);
    chk("bubble wr", W'(wb_reg_wr), 0);
    chk("bubble retired", W'(retired), 5);

    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1, 0, 1, 0, 10 + i, 0, $urandom(), 0);
      chk("stall data", wb_data, 32'h99);
      chk("stall addr", W'(wb_reg_addr), 5);
      chk("stall retired", W'(retired), 5);
    end
    step(0, 0, 1, 1, 0, 1, 0, 3, 0, 32'hABCD, 0);
    chk("release data", wb_data, 32'hABCD);
    chk("release retired", W'(retired), 6);

    // HALT reaches write-back; a trailing entry is still accepted and counted.
    step(0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    chk("halt entry o_halt", W'(halt_o), 0);
    chk("halt entry wr", W'(wb_reg_wr), 0);
    chk("halt entry retired", W'(retired), 6);
    step(0, 0, 1, 1, 0, 1, 0, 4, 0, 32'h55, 0);
    chk("halted o_halt", W'(halt_o), 1);
    chk("halted retired", W'(retired), 7);
    chk("halted data", wb_data, 32'h55);
    chk("halted wr", W'(wb_reg_wr), 0);
    step(0, 0, 1, 1, 0, 1, 0, 6, 0, 32'h66, 0);
    chk("frozen data", wb_data, 32'h55);
    chk("frozen retired", W'(retired), 7);
    chk("frozen o_halt", W'(halt_o), 1);

    step(0, 1, 1, 1, 0, 1, 0, 6, 0, 32'h66, 0);
    chk("flush o_halt", W'(halt_o), 0);
    chk("flush retired", W'(retired), 0);
    chk("flush wr", W'(wb_reg_wr), 0);
    step(0, 0, 1, 1, 0, 1, 0, 2, 0, 32'h77, 0);
    chk("post-flush data", wb_data, 32'h77);
    chk("post-flush wr", W'(wb_reg_wr), 1);
    chk("post-flush retired", W'(retired), 1);

    // A bubble carrying the HALT flag must not stop the program.
    step(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0, 1, 0, 2, 0, 32'h1, 0);
    chk("halt bubble o_halt", W'(halt_o), 0);

    // Saturation of the retired counter.
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < CNT_MAX + 5; i++)
      step(0, 0, 1, 1, 0, 1, 0, 1, 0, i, 0);
    chk("saturate retired", W'(retired), CNT_MAX);

    // Randomized traffic: occasional reset, flush and HALT, frequent stalls.
    for (int i = 0; i < 600; i++) step_rand(1, 4, 75, 6);
    for (int i = 0; i < 200; i++) step_rand(0, 1, 90, 0);

    chk_on = 0;
    @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
